fetch_stage: RTL and testbench

//  Instruction-fetch stage of the MIPS pipeline: PC register, word-addressed instruction memory,

---
 rtl/mips_pkg.sv | 19 +
 rtl/fetch_stage_if.sv | 31 +++
 rtl/instr_mem.sv | 22 ++
 rtl/fetch_stage.sv | 62 ++++++
 tb/tb_fetch_stage.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// MIPS constants shared by the fetch stage, main control decoder and ALU control.
// Also holds the jump-target formation used by the fetch stage.
package mips_pkg;
   localparam int INSTR_W = 32;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

   // J-format target keeps the 256 MB region of the delay-slot PC.
   function automatic logic [31:0] jump_addr(input logic [31:0] pc4, input logic [25:0] index);
      return {pc4[31:28], index, 2'b00};
   endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: redirect/stall controls, imem load port and the IF/ID register outputs.
// The fetch stage uses the slave view; the surrounding pipeline (or bench) uses master.
interface fetch_stage_if #(parameter int ADDR_W = 8);
   import mips_pkg::*;

   logic                stall;
   logic                branch_taken;
   logic [31:0]         branch_target;
   logic                jump;
   logic [25:0]         jump_index;
   logic                imem_we;
   logic [ADDR_W-1:0]   imem_waddr;
   logic [INSTR_W-1:0]  imem_wdata;
   logic [31:0]         pc;
   logic [INSTR_W-1:0]  if_id_instr;
   logic [31:0]         if_id_pc4;
   logic                if_id_valid;
   logic [5:0]          opcode;

   modport master (
      output stall, branch_taken, branch_target, jump, jump_index,
             imem_we, imem_waddr, imem_wdata,
      input  pc, if_id_instr, if_id_pc4, if_id_valid, opcode
   );

   modport slave (
      input  stall, branch_taken, branch_target, jump, jump_index,
             imem_we, imem_waddr, imem_wdata,
      output pc, if_id_instr, if_id_pc4, if_id_valid, opcode
   );
endinterface

// File: rtl/instr_mem.sv
// Word-addressed instruction memory: one synchronous write port, one asynchronous read port.
// A read of the address being written returns the old word until the edge.
module instr_mem
   import mips_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic                clk,
   input  logic                we,
   input  logic [ADDR_W-1:0]   waddr,
   input  logic [INSTR_W-1:0]  wdata,
   input  logic [ADDR_W-1:0]   raddr,
   output logic [INSTR_W-1:0]  rdata
);
   logic [INSTR_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC selection and IF/ID pipeline register.
// Redirect priority: branch (from EX) > jump (from ID) > stall > sequential PC+4.
module fetch_stage
   import mips_pkg::*;
#(
   parameter int          ADDR_W   = 8,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          reset,
   fetch_stage_if.slave  bus
);
   logic [31:0]         pc_q;
   logic [31:0]         pc_plus4;
   logic [INSTR_W-1:0]  fetch_word;
   logic [INSTR_W-1:0]  instr_q;
   logic [31:0]         pc4_q;
   logic                valid_q;
   logic                unused_bits;

   instr_mem #(.ADDR_W(ADDR_W)) u_imem (
      .clk   (clk),
      .we    (bus.imem_we),
      .waddr (bus.imem_waddr),
      .wdata (bus.imem_wdata),
      .raddr (pc_q[ADDR_W+1:2]),
      .rdata (fetch_word)
   );

   assign pc_plus4 = pc_q + 32'd4;

   // Flushes leave if_id_pc4 untouched; it is meaningless while valid is low.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q    <= RESET_PC;
         instr_q <= NOP_INSTR;
         pc4_q   <= '0;
         valid_q <= 1'b0;
      end else if (bus.branch_taken) begin
         pc_q    <= {bus.branch_target[31:2], 2'b00};
         instr_q <= NOP_INSTR;
         valid_q <= 1'b0;
      end else if (bus.jump) begin
         pc_q    <= jump_addr(pc4_q, bus.jump_index);
         instr_q <= NOP_INSTR;
         valid_q <= 1'b0;
      end else if (!bus.stall) begin
         pc_q    <= pc_plus4;
         instr_q <= fetch_word;
         pc4_q   <= pc_plus4;
         valid_q <= 1'b1;
      end
   end

   assign bus.pc          = pc_q;
   assign bus.if_id_instr = instr_q;
   assign bus.if_id_pc4   = pc4_q;
   assign bus.if_id_valid = valid_q;
   assign bus.opcode      = instr_q[31:26];

   assign unused_bits = ^bus.branch_target[1:0];
endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage: reset, stall, branch, jump, redirect conflict,
// imem read-during-write, address/PC wrap and reset during a redirect.
module tb_fetch_stage;
   import mips_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   passed = 0;
   int   total = 0;
   logic [31:0] exp_mem [256];

   fetch_stage_if #(.ADDR_W(8)) bus ();

   fetch_stage #(.ADDR_W(8), .RESET_PC(32'h0000_0000)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout: bench did not reach its summary, required completion");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [96:0] full_snap();
      return {bus.pc, bus.if_id_instr, bus.if_id_pc4, bus.if_id_valid};
   endfunction

   function automatic logic [64:0] flush_snap();
      return {bus.pc, bus.if_id_instr, bus.if_id_valid};
   endfunction

   task automatic idle_inputs();
      bus.stall = 1'b0;
      bus.branch_taken = 1'b0;
      bus.branch_target = '0;
      bus.jump = 1'b0;
      bus.jump_index = '0;
      bus.imem_we = 1'b0;
      bus.imem_waddr = '0;
      bus.imem_wdata = '0;
   endtask

   task automatic test_reset();
      logic [96:0] e;
      for (int i = 0; i < 256; i++) exp_mem[i] = 32'h2000_0000 | i;
      exp_mem[0]   = 32'h8C01_0004;
      exp_mem[1]   = 32'h2002_0005;
      exp_mem[2]   = 32'h0000_0000;
      exp_mem[3]   = 32'hAC01_0008;
      exp_mem[16]  = 32'h1000_FFFF;
      exp_mem[32]  = 32'h0800_0123;
      exp_mem[255] = 32'hAC1F_00FF;
      reset = 1'b1;
      idle_inputs();
      for (int i = 0; i < 256; i++) begin
         bus.imem_we = 1'b1;
         bus.imem_waddr = i[7:0];
         bus.imem_wdata = exp_mem[i];
         tick();
      end
      bus.imem_we = 1'b0;
      tick();
      tick();
      e = {32'h0, 32'h0, 32'h0, 1'b0}; total++;
      if (full_snap() !== e) $display("FAIL reset_state got %h required %h", full_snap(), e); else passed++;
      reset = 1'b0;
      tick();
      e = {32'h4, 32'h8C01_0004, 32'h4, 1'b1}; total++;
      if (full_snap() !== e) $display("FAIL first_fetch got %h required %h", full_snap(), e); else passed++;
      total++;
      if (bus.opcode !== 6'h23) $display("FAIL first_opcode got %h required %h", bus.opcode, 6'h23); else passed++;
      tick();
      e = {32'h8, 32'h2002_0005, 32'h8, 1'b1}; total++;
      if (full_snap() !== e) $display("FAIL second_fetch got %h required %h", full_snap(), e); else passed++;
   endtask

   task automatic test_stall();
      logic [96:0] e;
      bus.stall = 1'b1;
      e = {32'h8, 32'h2002_0005, 32'h8, 1'b1};
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (full_snap() !== e) $display("FAIL stall_hold%0d got %h required %h", i, full_snap(), e); else passed++;
      end
      bus.stall = 1'b0;
      tick();
      e = {32'hC, 32'h0000_0000, 32'hC, 1'b1}; total++;
      if (full_snap() !== e) $display("FAIL stall_resume got %h required %h", full_snap(), e); else passed++;
   endtask

   task automatic test_branch();
      logic [96:0] e;
      logic [64:0] f;
      bus.branch_taken = 1'b1;
      bus.branch_target = 32'h0000_0041;
      tick();
      bus.branch_taken = 1'b0;
      f = {32'h40, 32'h0, 1'b0}; total++;
      if (flush_snap() !== f) $display("FAIL branch_flush got %h required %h", flush_snap(), f); else passed++;
      tick();
      e = {32'h44, exp_mem[16], 32'h44, 1'b1}; total++;
      if (full_snap() !== e) $display("FAIL branch_target_fetch got %h required %h", full_snap(), e); else passed++;
      total++;
      if (bus.opcode !== OP_BEQ) $display("FAIL branch_opcode got %h required %h", bus.opcode, OP_BEQ); else passed++;
   endtask

   task automatic test_jump();
      logic [96:0] e;
      logic [64:0] f;
      bus.branch_taken = 1'b1;
      bus.branch_target = 32'h1000_0004;
      tick();
      bus.branch_taken = 1'b0;
      tick();
      e = {32'h1000_0008, 32'h2002_0005, 32'h1000_0008, 1'b1}; total++;
      if (full_snap() !== e) $display("FAIL jump_setup got %h required %h", full_snap(), e); else passed++;
      bus.jump = 1'b1;
      bus.jump_index = 26'h10;
      tick();
      bus.jump = 1'b0;
      f = {32'h1000_0040, 32'h0, 1'b0}; total++;
      if (flush_snap() !== f) $display("FAIL jump_flush got %h required %h", flush_snap(), f); else passed++;
      tick();
      e = {32'h1000_0044, exp_mem[16], 32'h1000_0044, 1'b1}; total++;
      if (full_snap() !== e) $display("FAIL jump_target_fetch got %h required %h", full_snap(), e); else passed++;
   endtask

   task automatic test_conflict();
      logic [96:0] e;
      logic [64:0] f;
      bus.branch_taken = 1'b1;
      bus.branch_target = 32'h0000_0083;
      bus.jump = 1'b1;
      bus.jump_index = 26'h3FF_FFFF;
      bus.stall = 1'b1;
      tick();
      idle_inputs();
      f = {32'h80, 32'h0, 1'b0}; total++;
      if (flush_snap() !== f) $display("FAIL conflict_flush got %h required %h", flush_snap(), f); else passed++;
      tick();
      e = {32'h84, exp_mem[32], 32'h84, 1'b1}; total++;
      if (full_snap() !== e) $display("FAIL conflict_fetch got %h required %h", full_snap(), e); else passed++;
      total++;
      if (bus.opcode !== OP_J) $display("FAIL conflict_opcode got %h required %h", bus.opcode, OP_J); else passed++;
   endtask

   task automatic test_read_during_write();
      logic [96:0] e;
      bus.imem_we = 1'b1;
      bus.imem_waddr = 8'd33;
      bus.imem_wdata = 32'hDEAD_BEEF;
      tick();
      bus.imem_we = 1'b0;
      e = {32'h88, exp_mem[33], 32'h88, 1'b1}; total++;
      if (full_snap() !== e) $display("FAIL rdw_old_word got %h required %h", full_snap(), e); else passed++;
      exp_mem[33] = 32'hDEAD_BEEF;
      bus.branch_taken = 1'b1;
      bus.branch_target = 32'h0000_0084;
      tick();
      bus.branch_taken = 1'b0;
      tick();
      e = {32'h88, 32'hDEAD_BEEF, 32'h88, 1'b1}; total++;
      if (full_snap() !== e) $display("FAIL rdw_new_word got %h required %h", full_snap(), e); else passed++;
   endtask

   task automatic test_wrap();
      logic [96:0] e;
      bus.branch_taken = 1'b1;
      bus.branch_target = 32'h0000_03FC;
      tick();
      bus.branch_taken = 1'b0;
      tick();
      e = {32'h400, exp_mem[255], 32'h400, 1'b1}; total++;
      if (full_snap() !== e) $display("FAIL wrap_last_word got %h required %h", full_snap(), e); else passed++;
      tick();
      e = {32'h404, exp_mem[0], 32'h404, 1'b1}; total++;
      if (full_snap() !== e) $display("FAIL wrap_addr_zero got %h required %h", full_snap(), e); else passed++;
      bus.branch_taken = 1'b1;
      bus.branch_target = 32'hFFFF_FFFE;
      tick();
      bus.branch_taken = 1'b0;
      tick();
      e = {32'h0, exp_mem[255], 32'h0, 1'b1}; total++;
      if (full_snap() !== e) $display("FAIL wrap_pc32 got %h required %h", full_snap(), e); else passed++;
   endtask

   task automatic test_reset_mid_redirect();
      logic [96:0] e;
      reset = 1'b1;
      bus.branch_taken = 1'b1;
      bus.branch_target = 32'h0000_0100;
      bus.jump = 1'b1;
      bus.jump_index = 26'h20;
      bus.stall = 1'b1;
      tick();
      e = {32'h0, 32'h0, 32'h0, 1'b0}; total++;
      if (full_snap() !== e) $display("FAIL reset_mid_redirect got %h required %h", full_snap(), e); else passed++;
      reset = 1'b0;
      idle_inputs();
      tick();
      e = {32'h4, exp_mem[0], 32'h4, 1'b1}; total++;
      if (full_snap() !== e) $display("FAIL reset_refetch got %h required %h", full_snap(), e); else passed++;
   endtask

   initial begin
      test_reset();
      test_stall();
      test_branch();
      test_jump();
      test_conflict();
      test_read_during_write();
      test_wrap();
      test_reset_mid_redirect();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
